instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 tb/tb_instr_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Assembles MIPS-style instruction fields into 32-bit words and streams them
// into instruction memory from a start address, one word per accepted handshake.
module instr_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        im_we,
   output logic [9:0]  im_addr,
   output logic [31:0] im_wdata,
   output logic [10:0] count,
   output logic        err,
   output logic        full,
   output logic [1:0]  dbg_state
);

   // Handshake: a field set is consumed on a cycle where in_valid and in_ready
   // are both high; in_ready never depends on in_valid.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_FULL = 2'd2} state_e;
   typedef enum logic [1:0] {F_R = 2'd0, F_I = 2'd1, F_J = 2'd2} fmt_e;

   state_e      state_q, state_d;
   logic [9:0]  ptr_q, ptr_d;
   logic [10:0] count_q, count_d;
   logic        err_q, err_d;
   logic        full_q, full_d;
   logic        we_q, we_d;
   logic [9:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   fmt_e        fmt;
   logic        legal;
   logic [5:0]  code;
   logic [4:0]  rt_eff, rd_eff;
   logic [31:0] word;
   logic        hs;

   always_comb begin
      fmt   = F_R;
      legal = 1'b1;
      code  = 6'h00;
      case (mnem)
         5'd0:  code = 6'h20;
         5'd1:  code = 6'h22;
         5'd2:  code = 6'h24;
         5'd3:  code = 6'h25;
         5'd4:  code = 6'h2A;
         5'd5:  code = 6'h2B;
         5'd6:  code = 6'h21;
         5'd7:  code = 6'h23;
         5'd8:  code = 6'h27;
         5'd9:  code = 6'h08;
         5'd10: code = 6'h09;
         5'd11: begin fmt = F_I; code = 6'h08; end
         5'd12: begin fmt = F_I; code = 6'h0D; end
         5'd13: begin fmt = F_I; code = 6'h23; end
         5'd14: begin fmt = F_I; code = 6'h2B; end
         5'd15: begin fmt = F_I; code = 6'h04; end
         5'd16: begin fmt = F_I; code = 6'h05; end
         5'd17: begin fmt = F_J; code = 6'h02; end
         5'd18: begin fmt = F_J; code = 6'h03; end
         default: legal = 1'b0;
      endcase
   end

   // jr ignores rt and rd, jalr ignores rt; zero them so the word is canonical.
   always_comb begin
      rt_eff = (mnem == 5'd9 || mnem == 5'd10) ? 5'd0 : rt;
      rd_eff = (mnem == 5'd9) ? 5'd0 : rd;
      case (fmt)
         F_I:     word = {code, rs, rt, imm};
         F_J:     word = {code, target};
         default: word = {6'b0, rs, rt_eff, rd_eff, 5'b0, code};
      endcase
   end

   assign in_ready = (state_q == S_ACTIVE) & ~start;
   assign hs       = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      err_d   = err_q;
      full_d  = full_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (start) begin
         state_d = S_ACTIVE;
         ptr_d   = base_addr;
         count_d = 11'd0;
         err_d   = 1'b0;
         full_d  = 1'b0;
      end else if (hs) begin
         if (legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            count_d = count_q + 11'd1;
            // The last word of the address space closes the load; ptr stays put.
            if (ptr_q == 10'h3FF) begin
               state_d = S_FULL;
               full_d  = 1'b1;
            end else begin
               ptr_d = ptr_q + 10'd1;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= 10'd0;
         count_q <= 11'd0;
         err_q   <= 1'b0;
         full_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 10'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         err_q   <= err_d;
         full_q  <= full_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // A write registered just before reset is dropped rather than committed.
   assign im_we     = we_q & ~reset;
   assign im_addr   = addr_q;
   assign im_wdata  = wdata_q;
   assign count     = count_q;
   assign err       = err_q;
   assign full      = full_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, random fields and hand-built corner
// sequences, with every memory write checked against an expected queue.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready;
   logic [9:0]  base_addr;
   logic [4:0]  mnem, rs, rt, rd;
   logic [15:0] imm;
   logic [25:0] target;
   logic        im_we, err, full;
   logic [9:0]  im_addr;
   logic [31:0] im_wdata;
   logic [10:0] count;
   logic [1:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   logic [41:0] exp_q[$];

   // bench model of the loader
   logic [9:0]  m_ptr;
   logic [10:0] m_count;
   logic        m_err, m_full, m_ready;
   logic [9:0]  last_addr;
   logic [31:0] last_data;

   typedef struct {
      logic [4:0]  m, rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tg;
      logic        legal;
      logic [31:0] word;
   } vec_t;
   vec_t tbl[20];

   instr_encoder dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem), .rs(rs), .rt(rt),
      .rd(rd), .imm(imm), .target(target), .im_we(im_we), .im_addr(im_addr),
      .im_wdata(im_wdata), .count(count), .err(err), .full(full),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every observed write must match the oldest expected write.
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {im_addr, im_wdata}, 42'h0);
         end else begin
            logic [41:0] e;
            e = exp_q.pop_front();
            check("write_addr", {32'h0, im_addr}, {32'h0, e[41:32]});
            check("write_data", {10'h0, im_wdata}, {10'h0, e[31:0]});
         end
      end
   end

   function automatic logic [32:0] ref_enc(input logic [4:0] m, r_s, r_t, r_d,
                                           input logic [15:0] im, input logic [25:0] tg);
      logic [31:0] rbase;
      rbase = {6'd0, r_s, r_t, r_d, 11'd0};
      case (m)
         5'd0:  return {1'b1, rbase | 32'h20};
         5'd1:  return {1'b1, rbase | 32'h22};
         5'd2:  return {1'b1, rbase | 32'h24};
         5'd3:  return {1'b1, rbase | 32'h25};
         5'd4:  return {1'b1, rbase | 32'h2A};
         5'd5:  return {1'b1, rbase | 32'h2B};
         5'd6:  return {1'b1, rbase | 32'h21};
         5'd7:  return {1'b1, rbase | 32'h23};
         5'd8:  return {1'b1, rbase | 32'h27};
         5'd9:  return {1'b1, {6'd0, r_s, 15'd0, 6'h08}};
         5'd10: return {1'b1, {6'd0, r_s, 5'd0, r_d, 5'd0, 6'h09}};
         5'd11: return {1'b1, 32'h20000000 | {6'd0, r_s, r_t, im}};
         5'd12: return {1'b1, 32'h34000000 | {6'd0, r_s, r_t, im}};
         5'd13: return {1'b1, 32'h8C000000 | {6'd0, r_s, r_t, im}};
         5'd14: return {1'b1, 32'hAC000000 | {6'd0, r_s, r_t, im}};
         5'd15: return {1'b1, 32'h10000000 | {6'd0, r_s, r_t, im}};
         5'd16: return {1'b1, 32'h14000000 | {6'd0, r_s, r_t, im}};
         5'd17: return {1'b1, 32'h08000000 | {6'd0, tg}};
         5'd18: return {1'b1, 32'h0C000000 | {6'd0, tg}};
         default: return 33'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [9:0] b);
      start = 1'b1;
      base_addr = b;
      step();
      start = 1'b0;
      m_ptr = b; m_count = 11'd0; m_err = 1'b0; m_full = 1'b0; m_ready = 1'b1;
      check("start_count", {31'h0, count}, {31'h0, m_count});
      check("start_flags", {40'h0, err, full}, 42'h0);
      check("start_state", {40'h0, dbg_state}, 42'd1);
   endtask

   // Presents one field set (in_valid stays high) and advances one cycle.
   task automatic issue(input logic [4:0] m, r_s, r_t, r_d, input logic [15:0] im,
                        input logic [25:0] tg, input logic legal, input logic [31:0] word);
      mnem = m; rs = r_s; rt = r_t; rd = r_d; imm = im; target = tg;
      in_valid = 1'b1;
      #1;
      check("in_ready", {41'h0, in_ready}, {41'h0, m_ready});
      if (m_ready) begin
         if (legal) begin
            exp_q.push_back({m_ptr, word});
            last_addr = m_ptr;
            last_data = word;
            m_count = m_count + 11'd1;
            if (m_ptr == 10'h3FF) begin
               m_full = 1'b1;
               m_ready = 1'b0;
            end else begin
               m_ptr = m_ptr + 10'd1;
            end
         end else begin
            m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("count", {31'h0, count}, {31'h0, m_count});
      check("err", {41'h0, err}, {41'h0, m_err});
      check("full", {41'h0, full}, {41'h0, m_full});
   endtask

   task automatic check_zero(input string name);
      check({name, "_we"}, {41'h0, im_we}, 42'h0);
      check({name, "_addr"}, {32'h0, im_addr}, 42'h0);
      check({name, "_data"}, {10'h0, im_wdata}, 42'h0);
      check({name, "_count"}, {31'h0, count}, 42'h0);
      check({name, "_flags"}, {40'h0, err, full}, 42'h0);
      check({name, "_ready"}, {41'h0, in_ready}, 42'h0);
      check({name, "_state"}, {40'h0, dbg_state}, 42'h0);
   endtask

   initial begin
      tbl[0]  = '{5'd11, 5'd0,  5'd8,  5'd5,  16'hFFFF, 26'd0,       1'b1, 32'h2008FFFF};
      tbl[1]  = '{5'd14, 5'd29, 5'd9,  5'd0,  16'h0004, 26'd0,       1'b1, 32'hAFA90004};
      tbl[2]  = '{5'd18, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h10,      1'b1, 32'h0C000010};
      tbl[3]  = '{5'd9,  5'd31, 5'd5,  5'd7,  16'h0000, 26'd0,       1'b1, 32'h03E00008};
      tbl[4]  = '{5'd25, 5'd1,  5'd2,  5'd3,  16'h1111, 26'd0,       1'b0, 32'h0};
      tbl[5]  = '{5'd1,  5'd4,  5'd5,  5'd6,  16'hABCD, 26'd0,       1'b1, 32'h00853022};
      tbl[6]  = '{5'd8,  5'd31, 5'd31, 5'd31, 16'h0000, 26'd0,       1'b1, 32'h03FFF827};
      tbl[7]  = '{5'd10, 5'd2,  5'd9,  5'd31, 16'h0000, 26'd0,       1'b1, 32'h0040F809};
      tbl[8]  = '{5'd12, 5'd1,  5'd2,  5'd3,  16'h1234, 26'd0,       1'b1, 32'h34221234};
      tbl[9]  = '{5'd13, 5'd29, 5'd8,  5'd0,  16'h0010, 26'd0,       1'b1, 32'h8FA80010};
      tbl[10] = '{5'd15, 5'd1,  5'd0,  5'd0,  16'hFFFE, 26'd0,       1'b1, 32'h1020FFFE};
      tbl[11] = '{5'd16, 5'd3,  5'd4,  5'd0,  16'h0002, 26'd0,       1'b1, 32'h14640002};
      tbl[12] = '{5'd17, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
      tbl[13] = '{5'd19, 5'd0,  5'd0,  5'd0,  16'h0000, 26'd0,       1'b0, 32'h0};
      tbl[14] = '{5'd4,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,       1'b1, 32'h0022182A};
      tbl[15] = '{5'd2,  5'd7,  5'd0,  5'd1,  16'h0000, 26'd0,       1'b1, 32'h00E00824};
      tbl[16] = '{5'd3,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,       1'b1, 32'h00221825};
      tbl[17] = '{5'd5,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,       1'b1, 32'h0022182B};
      tbl[18] = '{5'd31, 5'd0,  5'd0,  5'd0,  16'h0000, 26'd0,       1'b0, 32'h0};
      tbl[19] = '{5'd7,  5'd1,  5'd2,  5'd3,  16'h0000, 26'd0,       1'b1, 32'h00221823};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; base_addr = 10'd0;
      mnem = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
      m_ptr = 10'd0; m_count = 11'd0; m_err = 1'b0; m_full = 1'b0; m_ready = 1'b0;
      last_addr = 10'd0; last_data = 32'd0;
      repeat (3) step();
      check_zero("reset");
      reset = 1'b0;
      step();
      check("idle_ready", {41'h0, in_ready}, 42'h0);

      // single add, then the table back-to-back
      do_start(10'd0);
      issue(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b1, 32'h00221820);
      foreach (tbl[i])
         issue(tbl[i].m, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].tg,
               tbl[i].legal, tbl[i].word);
      in_valid = 1'b0;
      step();
      check("idle_we", {41'h0, im_we}, 42'h0);
      check("hold_addr", {32'h0, im_addr}, {32'h0, last_addr});
      check("hold_data", {10'h0, im_wdata}, {10'h0, last_data});

      // random field sets
      do_start(10'd500);
      for (int i = 0; i < 24; i++) begin
         logic [4:0]  m, a, b, c;
         logic [15:0] im;
         logic [25:0] tg;
         logic [32:0] r;
         m = 5'($urandom_range(0, 31)); a = 5'($urandom_range(0, 31));
         b = 5'($urandom_range(0, 31)); c = 5'($urandom_range(0, 31));
         im = 16'($urandom_range(0, 65535)); tg = 26'($urandom);
         r = ref_enc(m, a, b, c, im, tg);
         issue(m, a, b, c, im, tg, r[32], r[31:0]);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
         end
      end
      in_valid = 1'b0;
      step();

      // top of the address space
      do_start(10'd1022);
      issue(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b1, 32'h00221820);
      issue(5'd17, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123, 1'b1, 32'h08000123);
      check("full_state", {40'h0, dbg_state}, 42'd2);
      issue(5'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'd0, 1'b1, 32'h00853020);
      in_valid = 1'b0;
      step();

      // start coincident with in_valid: fields dropped
      mnem = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3;
      in_valid = 1'b1; start = 1'b1; base_addr = 10'd100;
      #1;
      check("start_blocks_ready", {41'h0, in_ready}, 42'h0);
      step();
      start = 1'b0; in_valid = 1'b0;
      m_ptr = 10'd100; m_count = 11'd0; m_err = 1'b0; m_full = 1'b0; m_ready = 1'b1;
      step();
      check("start_drop_count", {31'h0, count}, 42'h0);
      issue(5'd6, 5'd1, 5'd2, 5'd3, 16'h0, 26'd0, 1'b1, 32'h00221821);
      in_valid = 1'b0;
      step();

      // reset right after a handshake discards the pending write
      mnem = 5'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("reset_kills_we", {41'h0, im_we}, 42'h0);
      step();
      check_zero("mid_reset");
      reset = 1'b0;
      step();

      check("queue_drained", 42'(exp_q.size()), 42'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
